kernel_pr_start_token_reader: RTL and testbench
===============================================

// Module: kernel_pr_start_token_reader
// PURPOSE
// - Consumer end of a start-propagation FIFO between two dataflow processes.
// - Pops one start token per downstream task and drives that process's ap_start/ap_ready/ap_done handshake.
// - Caps in-flight tasks (started, not yet done) at MAX_INFLIGHT and reports idle/occupancy to the control FSM.
// PARAMETERS
// - DATA_WIDTH    1  start-token payload width (matches FIFO DATA_WIDTH)
// - MAX_INFLIGHT  4  max tasks started but not done; range 1..2**CNT_WIDTH-1
// - CNT_WIDTH     3  width of the in-flight counter
// PORTS
// - clk            in   1           single clock, rising edge
// - reset_n        in   1           synchronous, active-low reset
// - enable         in   1           0 = pop no new tokens; current handshake still completes
// - if_empty_n     in   1           FIFO holds a token; if_dout valid while high
// - if_dout        in   DATA_WIDTH  FIFO head token
// - if_read        out  1           pop strobe, combinational, one cycle per token
// - if_read_ce     out  1           constant 1
// - ap_start       out  1           start request to the downstream process
// - ap_ready       in   1           downstream accepted the start
// - ap_done        in   1           downstream finished one task, one-cycle pulse
// - tok_data       out  DATA_WIDTH  payload of the token being started; held while ap_start=1
// - inflight       out  CNT_WIDTH   tasks accepted (ap_ready) but not yet done
// - all_idle       out  1           state==S_IDLE && inflight==0 && !if_empty_n
// - err_underflow  out  1           sticky: ap_done seen while inflight==0
// BEHAVIOUR
// - Reset values: ap_start=0, if_read=0 (comb), tok_data=0, inflight=0, err_underflow=0, state=S_IDLE.
// - FSM states: S_IDLE, S_START.
// - room = (inflight < MAX_INFLIGHT) in S_IDLE. In S_START with ap_ready=1: room = (inflight+1-ap_done < MAX_INFLIGHT).
// - pop = enable & if_empty_n & room & (S_IDLE | (S_START & ap_ready)); if_read = pop.
// - On pop: tok_data <= if_dout; next state S_START.
// - S_IDLE -> S_START on pop. Token-to-ap_start latency is 1 cycle.
// - S_START: ap_start=1 until ap_ready is sampled 1.
//   - On ap_ready with a pop in the same cycle: stay in S_START (back-to-back start, no bubble).
//   - On ap_ready with no pop: go to S_IDLE.
// - inflight update: +1 on (S_START & ap_ready), -1 on ap_done.
//   - Both in the same cycle: inflight unchanged.
//   - Never wraps: ap_done at 0 is ignored for counting and sets err_underflow.
//   - Increment at MAX_INFLIGHT cannot occur because room gates pop.
// - enable dropped while in S_START: handshake completes, then the FSM returns to S_IDLE and no further pop occurs.
// - FIFO empty: the block waits in S_IDLE with if_read=0.
// - Reset mid-task: ap_start drops the next cycle, inflight clears, and no token is popped during reset.
// - err_underflow clears only on reset.
// CONFIGURATION
// - Macro KERNEL_PR_START_STATS_EN.
//   - Defined: adds outputs stat_starts[31:0] (+1 per ap_ready in S_START) and stat_stalls[31:0] (+1 per cycle with ap_start & !ap_ready).
//   - Both counters wrap modulo 2**32 and reset to 0.
//   - Undefined: these ports and their registers do not exist; all other behaviour is identical.
// STRUCTURE
// - Package kernel_pr_start_pkg:
//   - state typedef (S_IDLE=1'b0, S_START=1'b1)
//   - STAT_WIDTH=32
//   - function room_ok(inflight, inc, dec, max)
// - Sub-module kernel_pr_start_inflight_cnt: up/down counter, inputs inc/dec, outputs cnt and underflow pulse.
// - Top level holds the FSM, pop logic, token register and optional stats.
// TESTING
// - Reset, then FIFO supplies 1 token (payload 1), ap_ready after 2 cycles -> if_read pulses once; ap_start high 3 cycles; tok_data=1; inflight=1.
// - 3 tokens queued, ap_ready held 1 -> pops on 3 consecutive cycles; ap_start continuously high; inflight reaches 3.
// - MAX_INFLIGHT=4, 6 tokens queued, no ap_done -> exactly 4 starts and if_read stops; one ap_done -> exactly 1 more pop.
// - ap_ready and ap_done in the same cycle at inflight=2 -> inflight stays 2.
// - ap_done at inflight=0 -> err_underflow=1 and stays 1; inflight stays 0.
// - reset_n=0 while in S_START -> next cycle ap_start=0, inflight=0, all_idle=1 once the FIFO is empty.
// - STATS_EN build, 2 starts with 3 stall cycles total -> stat_starts=2, stat_stalls=3.

Source files
------------

// File: rtl/kernel_pr_start_pkg.sv
// kernel_pr_start_pkg: shared state encoding, stats width and the in-flight room check.
package kernel_pr_start_pkg;
  typedef enum logic {S_IDLE = 1'b0, S_START = 1'b1} state_e;
  localparam int unsigned STAT_WIDTH = 32;
  function automatic logic room_ok(input int unsigned inflight, input logic inc, input logic dec,
                                   input int unsigned max);
    return (inflight + 32'(inc) - 32'(dec)) < max;
  endfunction
endpackage

// File: rtl/kernel_pr_start_token_reader_inflight_cnt.sv
// kernel_pr_start_inflight_cnt: saturating-at-zero up/down counter of in-flight tasks.
module kernel_pr_start_inflight_cnt #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         underflow
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    underflow = dec && cnt_q == '0;
    cnt_d = cnt_q + W'(inc) - W'(dec && !underflow);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
endmodule

// File: rtl/kernel_pr_start_token_reader.sv
// kernel_pr_start_token_reader: pops start tokens and drives ap_start/ap_ready/ap_done with an in-flight cap.
// Optional stats counters enabled by defining KERNEL_PR_START_STATS_EN.
module kernel_pr_start_token_reader
  import kernel_pr_start_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 1,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_WIDTH    = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  if_empty_n,
  input  logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_read,
  output logic                  if_read_ce,
  output logic                  ap_start,
  input  logic                  ap_ready,
  input  logic                  ap_done,
  output logic [DATA_WIDTH-1:0] tok_data,
  output logic [CNT_WIDTH-1:0]  inflight,
  output logic                  all_idle,
`ifdef KERNEL_PR_START_STATS_EN
  output logic [STAT_WIDTH-1:0] stat_starts,
  output logic [STAT_WIDTH-1:0] stat_stalls,
`endif
  output logic                  err_underflow
);
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] tok_q, tok_d;
  logic                  err_q, err_d;
  logic                  fire, room, pop, uflow;
  kernel_pr_start_inflight_cnt #(.W(CNT_WIDTH)) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (fire),
    .dec      (ap_done),
    .cnt      (inflight),
    .underflow(uflow)
  );
  // A done at zero is not counted, so it must not free a slot either.
  always_comb begin
    fire = state_q == S_START && ap_ready;
    room = state_q == S_IDLE ? room_ok(32'(inflight), 1'b0, 1'b0, MAX_INFLIGHT)
                             : room_ok(32'(inflight), 1'b1, ap_done && inflight != '0, MAX_INFLIGHT);
    pop = reset_n && enable && if_empty_n && room && (state_q == S_IDLE || fire);
    state_d = pop ? S_START : (fire ? S_IDLE : state_q);
    tok_d = pop ? if_dout : tok_q;
    err_d = err_q | uflow;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tok_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tok_q <= tok_d;
      err_q <= err_d;
    end
  end
  assign if_read       = pop;
  assign if_read_ce    = 1'b1;
  assign ap_start      = state_q == S_START;
  assign tok_data      = tok_q;
  assign err_underflow = err_q;
  assign all_idle      = state_q == S_IDLE && inflight == '0 && !if_empty_n;
`ifdef KERNEL_PR_START_STATS_EN
  logic [STAT_WIDTH-1:0] starts_q, starts_d, stalls_q, stalls_d;
  always_comb begin
    starts_d = starts_q + STAT_WIDTH'(fire);
    stalls_d = stalls_q + STAT_WIDTH'(ap_start && !ap_ready);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starts_q <= '0;
      stalls_q <= '0;
    end else begin
      starts_q <= starts_d;
      stalls_q <= stalls_d;
    end
  end
  assign stat_starts = starts_q;
  assign stat_stalls = stalls_q;
`endif
endmodule

// File: tb/tb_kernel_pr_start_token_reader.sv
// tb_kernel_pr_start_token_reader: directed spec scenarios plus random traffic against a task-level reference model.
module tb_kernel_pr_start_token_reader;
  localparam int unsigned DW = 4;
  localparam int unsigned MAXI = 4;
  localparam int unsigned CW = 3;
  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, if_empty_n = 1'b0, ap_ready = 1'b0, ap_done = 1'b0;
  logic [DW-1:0] if_dout = '0;
  logic if_read, if_read_ce, ap_start, all_idle, err_underflow;
  logic [DW-1:0] tok_data;
  logic [CW-1:0] inflight;
`ifdef KERNEL_PR_START_STATS_EN
  logic [31:0] stat_starts, stat_stalls;
  int unsigned m_starts = 0, m_stalls = 0;
`endif
  int checks = 0, errors = 0, n_pops = 0;
  logic [DW-1:0] fifo[$];
  bit m_busy = 0, m_err = 0;
  logic [DW-1:0] m_tok = '0;
  int unsigned m_cnt = 0;
  kernel_pr_start_token_reader #(.DATA_WIDTH(DW), .MAX_INFLIGHT(MAXI), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .if_empty_n(if_empty_n), .if_dout(if_dout),
    .if_read(if_read), .if_read_ce(if_read_ce), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .tok_data(tok_data), .inflight(inflight), .all_idle(all_idle),
`ifdef KERNEL_PR_START_STATS_EN
    .stat_starts(stat_starts), .stat_stalls(stat_stalls),
`endif
    .err_underflow(err_underflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  // One cycle: drive at negedge, check combinational outputs, advance the model, check registers at next negedge.
  task automatic step(input bit rn, input bit en, input bit rdy, input bit dn, input bit push,
                      input logic [DW-1:0] pv);
    bit fire, dec_ok, room, pop;
    if (push) fifo.push_back(pv);
    reset_n = rn; enable = en; ap_ready = rdy; ap_done = dn;
    if_empty_n = fifo.size() != 0;
    if_dout = fifo.size() != 0 ? fifo[0] : '0;
    #1;
    fire = m_busy && rdy;
    dec_ok = dn && m_cnt > 0;
    room = m_busy ? (m_cnt + 1 - dec_ok < MAXI) : (m_cnt < MAXI);
    pop = rn && en && fifo.size() != 0 && room && (!m_busy || fire);
    check("if_read", 32'(if_read), 32'(pop));
    check("if_read_ce", 32'(if_read_ce), 1);
    check("all_idle", 32'(all_idle), 32'(!m_busy && m_cnt == 0 && fifo.size() == 0));
    if (!rn) begin
      m_busy = 0; m_tok = '0; m_cnt = 0; m_err = 0;
`ifdef KERNEL_PR_START_STATS_EN
      m_starts = 0; m_stalls = 0;
`endif
    end else begin
`ifdef KERNEL_PR_START_STATS_EN
      m_starts += fire; m_stalls += m_busy && !rdy;
`endif
      m_err = m_err || (dn && m_cnt == 0);
      m_cnt = m_cnt + fire - dec_ok;
      m_busy = pop || (m_busy && !rdy);
      if (pop) m_tok = fifo[0];
    end
    if (pop) begin
      void'(fifo.pop_front());
      n_pops++;
    end
    @(negedge clk);
    check("ap_start", 32'(ap_start), 32'(m_busy));
    check("tok_data", 32'(tok_data), 32'(m_tok));
    check("inflight", 32'(inflight), m_cnt);
    check("err_underflow", 32'(err_underflow), 32'(m_err));
`ifdef KERNEL_PR_START_STATS_EN
    check("stat_starts", stat_starts, m_starts);
    check("stat_stalls", stat_stalls, m_stalls);
`endif
  endtask
  task automatic do_reset();
    fifo.delete();
    step(0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, '0);
  endtask
  initial begin
    int hi;
    repeat (2) @(negedge clk);
    do_reset();
    check("rst_ap_start", 32'(ap_start), 0);
    check("rst_inflight", 32'(inflight), 0);
    // single token, ready after two stall cycles
    n_pops = 0; hi = 0;
    step(1, 1, 0, 0, 1, 4'd1);
    for (int i = 0; i < 3; i++) begin
      hi += ap_start;
      step(1, 1, i == 2, 0, 0, '0);
    end
    check("s1_pops", n_pops, 1);
    check("s1_start_cycles", hi, 3);
    check("s1_tok", 32'(tok_data), 1);
    check("s1_inflight", 32'(inflight), 1);
    // three tokens back to back
    do_reset();
    n_pops = 0;
    for (int i = 0; i < 3; i++) fifo.push_back(DW'(i + 5));
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0, '0);
    check("b2b_pops", n_pops, 3);
    check("b2b_inflight", 32'(inflight), 3);
    // in-flight cap
    do_reset();
    n_pops = 0;
    for (int i = 0; i < 6; i++) fifo.push_back(DW'(i));
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 0, '0);
    check("cap_pops", n_pops, 4);
    check("cap_inflight", 32'(inflight), 4);
    step(1, 1, 1, 1, 0, '0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0, '0);
    check("cap_pops_after_done", n_pops, 5);
    // simultaneous ready and done at inflight 2
    do_reset();
    for (int i = 0; i < 3; i++) fifo.push_back(DW'(i));
    step(1, 1, 0, 0, 0, '0);
    step(1, 1, 1, 0, 0, '0);
    step(1, 1, 1, 0, 0, '0);
    check("pre_same_inflight", 32'(inflight), 2);
    step(1, 1, 1, 1, 0, '0);
    check("same_cycle_inflight", 32'(inflight), 2);
    // underflow is sticky
    do_reset();
    step(1, 1, 0, 1, 0, '0);
    step(1, 1, 0, 0, 0, '0);
    check("uflow_err", 32'(err_underflow), 1);
    check("uflow_inflight", 32'(inflight), 0);
    // reset while starting
    do_reset();
    step(1, 1, 0, 0, 1, 4'd9);
    step(1, 1, 0, 0, 0, '0);
    fifo.delete();
    step(0, 1, 0, 0, 0, '0);
    check("midrst_ap_start", 32'(ap_start), 0);
    check("midrst_all_idle", 32'(all_idle), 1);
    // random traffic
    do_reset();
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 199) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, DW'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
